// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Shares the single data-memory port between requester A (CPU load/store
//   unit) and requester B (debug/DMA loader). A granted request is copied
//   into the memory-port registers, presented to the memory for exactly one
//   cycle (ACCESS), and acknowledged the following cycle (DONE) with the data
//   sampled from the memory at the end of ACCESS. Round-robin arbitration
//   alternates the ports when both are requesting.
//
// Ports
//   Clk, Reset                  clock, asynchronous active-low reset
//   a_req/a_wr/a_ad/a_wdata/a_cut  requester A access request and fields
//   a_ack, a_rdata              A completion pulse and read data
//   b_req/b_wr/b_ad/b_wdata/b_cut  requester B access request and fields
//   b_ack, b_rdata              B completion pulse and read data
//   Ad, WrData, MemWr, DMcut_sel   memory port, nonzero only during ACCESS
//   DM                          memory read data (combinational in memory)
//   busy                        high while in ACCESS or DONE
module dm_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          a_req,
  input  logic [2:0]    a_wr,
  input  logic [AW-1:0] a_ad,
  input  logic [DW-1:0] a_wdata,
  input  logic [1:0]    a_cut,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic [2:0]    b_wr,
  input  logic [AW-1:0] b_ad,
  input  logic [DW-1:0] b_wdata,
  input  logic [1:0]    b_cut,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] Ad,
  output logic [DW-1:0] WrData,
  output logic [2:0]    MemWr,
  output logic [1:0]    DMcut_sel,
  input  logic [DW-1:0] DM,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Port identifiers used by owner and rr_last.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t state;
  logic   owner;     // port whose access is in ACCESS/DONE
  logic   rr_last;   // port granted most recently

  logic          grant_valid;
  logic          grant_port;
  logic [2:0]    sel_wr;
  logic [AW-1:0] sel_ad;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    sel_cut;

  // Grant decision. In IDLE both ports compete; in DONE only the port that
  // is not being acknowledged may be granted, because the acknowledged port
  // is still holding its (already served) request this cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = PORT_A;
    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          grant_valid = 1'b1;
          grant_port  = ~rr_last;
        end else if (a_req) begin
          grant_valid = 1'b1;
          grant_port  = PORT_A;
        end else if (b_req) begin
          grant_valid = 1'b1;
          grant_port  = PORT_B;
        end
      end
      DONE: begin
        if (owner == PORT_A && b_req) begin
          grant_valid = 1'b1;
          grant_port  = PORT_B;
        end else if (owner == PORT_B && a_req) begin
          grant_valid = 1'b1;
          grant_port  = PORT_A;
        end
      end
      default: begin
        grant_valid = 1'b0;
        grant_port  = PORT_A;
      end
    endcase
  end

  assign sel_wr    = (grant_port == PORT_B) ? b_wr    : a_wr;
  assign sel_ad    = (grant_port == PORT_B) ? b_ad    : a_ad;
  assign sel_wdata = (grant_port == PORT_B) ? b_wdata : a_wdata;
  assign sel_cut   = (grant_port == PORT_B) ? b_cut   : a_cut;

  // The memory-port registers double as the latched copy of the granted
  // request: loaded at the grant edge, cleared at the edge ending ACCESS, so
  // the memory never sees a nonzero MemWr outside the single ACCESS cycle
  // and later changes on the request inputs cannot reach it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      owner     <= PORT_A;
      rr_last   <= PORT_B;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      Ad        <= '0;
      WrData    <= '0;
      MemWr     <= '0;
      DMcut_sel <= '0;
      busy      <= 1'b0;
    end else begin
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      Ad        <= '0;
      WrData    <= '0;
      MemWr     <= '0;
      DMcut_sel <= '0;
      case (state)
        ACCESS: begin
          // DM is captured for every access, writes included; the memory
          // commits a write on this same edge.
          if (owner == PORT_B) begin
            b_rdata <= DM;
            b_ack   <= 1'b1;
          end else begin
            a_rdata <= DM;
            a_ack   <= 1'b1;
          end
          busy  <= 1'b1;
          state <= DONE;
        end
        default: begin
          // IDLE and DONE share the grant path.
          if (grant_valid) begin
            Ad        <= sel_ad;
            WrData    <= sel_wdata;
            MemWr     <= sel_wr;
            DMcut_sel <= sel_cut;
            owner     <= grant_port;
            rr_last   <= grant_port;
            busy      <= 1'b1;
            state     <= ACCESS;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Directed bench for dm_arbiter with a little-endian byte memory attached
//   to the memory port. Inputs are driven and outputs sampled on the falling
//   edge of Clk.
module tb_dm_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          a_req, b_req;
  logic [2:0]    a_wr, b_wr;
  logic [AW-1:0] a_ad, b_ad;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [1:0]    a_cut, b_cut;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] Ad;
  logic [DW-1:0] WrData;
  logic [2:0]    MemWr;
  logic [1:0]    DMcut_sel;
  logic [DW-1:0] DM;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .a_req(a_req), .a_wr(a_wr), .a_ad(a_ad), .a_wdata(a_wdata), .a_cut(a_cut),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_ad(b_ad), .b_wdata(b_wdata), .b_cut(b_cut),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .Ad(Ad), .WrData(WrData), .MemWr(MemWr), .DMcut_sel(DMcut_sel),
    .DM(DM), .busy(busy)
  );

  // Byte-addressed memory: combinational read, write committed on the
  // rising edge while MemWr is nonzero. MemWr=3 reads back 1.
  logic [7:0] mem [0:65535];
  logic [7:0] m0, m1, m2, m3;
  assign m0 = mem[Ad];
  assign m1 = mem[Ad + 16'd1];
  assign m2 = mem[Ad + 16'd2];
  assign m3 = mem[Ad + 16'd3];
  assign DM = (MemWr == 3'd3)     ? 32'd1 :
              (DMcut_sel == 2'd1) ? {24'd0, m0} :
              (DMcut_sel == 2'd2) ? {16'd0, m1, m0} :
                                    {m3, m2, m1, m0};

  always @(posedge Clk) begin
    case (MemWr)
      3'd1, 3'd3: begin
        mem[Ad]         <= WrData[7:0];
        mem[Ad + 16'd1] <= WrData[15:8];
        mem[Ad + 16'd2] <= WrData[23:16];
        mem[Ad + 16'd3] <= WrData[31:24];
      end
      3'd2: mem[Ad] <= WrData[7:0];
      3'd4: begin
        mem[Ad]         <= WrData[7:0];
        mem[Ad + 16'd1] <= WrData[15:8];
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload_word(input logic [15:0] ad, input logic [31:0] val);
    mem[ad]         <= val[7:0];
    mem[ad + 16'd1] <= val[15:8];
    mem[ad + 16'd2] <= val[23:16];
    mem[ad + 16'd3] <= val[31:24];
  endtask

  // One complete access on a single port, starting and ending at a falling
  // edge with the arbiter idle.
  task automatic do_access(input bit is_b, input logic [2:0] wr, input logic [15:0] ad,
                           input logic [31:0] wd, input logic [1:0] cut,
                           input logic [31:0] exp_rd, input string tag);
    if (is_b) begin
      b_req = 1'b1; b_wr = wr; b_ad = ad; b_wdata = wd; b_cut = cut;
    end else begin
      a_req = 1'b1; a_wr = wr; a_ad = ad; a_wdata = wd; a_cut = cut;
    end
    @(negedge Clk);  // ACCESS
    check({tag, "_acc_busy"},  busy, 1'b1);
    check({tag, "_acc_ad"},    Ad, ad);
    check({tag, "_acc_memwr"}, MemWr, wr);
    check({tag, "_acc_wrdata"}, WrData, wd);
    check({tag, "_acc_cut"},   DMcut_sel, cut);
    check({tag, "_acc_acks"},  {a_ack, b_ack}, 2'b00);
    @(negedge Clk);  // DONE
    check({tag, "_done_ack"},   {a_ack, b_ack}, is_b ? 2'b01 : 2'b10);
    check({tag, "_done_rdata"}, is_b ? b_rdata : a_rdata, exp_rd);
    check({tag, "_done_memwr"}, MemWr, 3'd0);
    check({tag, "_done_ad"},    Ad, 16'd0);
    if (is_b) b_req = 1'b0; else a_req = 1'b0;
    @(negedge Clk);  // back in IDLE
    check({tag, "_idle_acks"},  {a_ack, b_ack}, 2'b00);
    check({tag, "_idle_busy"},  busy, 1'b0);
    check({tag, "_idle_rdata"}, is_b ? b_rdata : a_rdata, exp_rd);
  endtask

  initial begin
    Reset = 1'b0;
    a_req = 1'b0; a_wr = '0; a_ad = '0; a_wdata = '0; a_cut = '0;
    b_req = 1'b0; b_wr = '0; b_ad = '0; b_wdata = '0; b_cut = '0;
    for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    preload_word(16'hff10, 32'h11223344);
    preload_word(16'hff20, 32'h55667788);
    preload_word(16'hff40, 32'hDEADBEEF);
    preload_word(16'hff50, 32'h01010101);

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_ad", Ad, 16'd0);
    check("rst_wrdata", WrData, 32'd0);
    check("rst_memwr", MemWr, 3'd0);
    check("rst_cut", DMcut_sel, 2'd0);
    check("rst_acks", {a_ack, b_ack}, 2'b00);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_busy", busy, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    check("post_rst_busy", busy, 1'b0);

    // Contention from reset: A first, then strict alternation.
    a_req = 1'b1; a_wr = 3'd0; a_ad = 16'hff10; a_cut = 2'd0;
    b_req = 1'b1; b_wr = 3'd0; b_ad = 16'hff20; b_cut = 2'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      check($sformatf("cont%0d_acc_ad", k), Ad, k[0] ? 16'hff20 : 16'hff10);
      check($sformatf("cont%0d_acc_acks", k), {a_ack, b_ack}, 2'b00);
      check($sformatf("cont%0d_acc_memwr", k), MemWr, 3'd0);
      @(negedge Clk);
      check($sformatf("cont%0d_done_acks", k), {a_ack, b_ack}, k[0] ? 2'b01 : 2'b10);
      check($sformatf("cont%0d_done_rdata", k), k[0] ? b_rdata : a_rdata,
            k[0] ? 32'h55667788 : 32'h11223344);
      if (k == 5) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
    @(negedge Clk);
    check("cont_end_busy", busy, 1'b0);
    check("cont_end_acks", {a_ack, b_ack}, 2'b00);

    // Single read, byte write and byte/word read-back
    do_access(1'b0, 3'd0, 16'hff10, 32'h0, 2'd0, 32'h11223344, "single_rd");
    do_access(1'b1, 3'd2, 16'hff20, 32'hAABBCCDD, 2'd0, 32'h55667788, "byte_wr");
    do_access(1'b0, 3'd0, 16'hff20, 32'h0, 2'd1, 32'h000000DD, "byte_rd");
    do_access(1'b0, 3'd0, 16'hff20, 32'h0, 2'd0, 32'h556677DD, "word_rd");

    // Field change while the access is in flight
    a_req = 1'b1; a_wr = 3'd0; a_ad = 16'hff10; a_wdata = 32'h0; a_cut = 2'd0;
    @(negedge Clk);
    a_ad = 16'hff40;
    #1;
    check("stable_acc_ad", Ad, 16'hff10);
    @(negedge Clk);
    check("stable_done_ack", a_ack, 1'b1);
    check("stable_done_rdata", a_rdata, 32'h11223344);
    a_req = 1'b0;
    @(negedge Clk);
    check("stable_idle_busy", busy, 1'b0);

    // Special write reads back 1; the stored word is the written data
    do_access(1'b0, 3'd3, 16'hff30, 32'hCAFEBABE, 2'd0, 32'h00000001, "special_wr");
    do_access(1'b0, 3'd0, 16'hff30, 32'h0, 2'd0, 32'hCAFEBABE, "special_rd");

    // Halfword write on B, then halfword read
    do_access(1'b1, 3'd4, 16'hff34, 32'h12345678, 2'd2, 32'h00000000, "half_wr");
    do_access(1'b1, 3'd0, 16'hff34, 32'h0, 2'd2, 32'h00005678, "half_rd");

    // Reset in the middle of an ACCESS of a word write
    a_req = 1'b1; a_wr = 3'd1; a_ad = 16'hff50; a_wdata = 32'h0BADF00D; a_cut = 2'd0;
    @(negedge Clk);
    check("rstmid_acc_memwr", MemWr, 3'd1);
    #1 Reset = 1'b0;
    #1;
    check("rstmid_ad", Ad, 16'd0);
    check("rstmid_memwr", MemWr, 3'd0);
    check("rstmid_wrdata", WrData, 32'd0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_a_ack", a_ack, 1'b0);
    check("rstmid_a_rdata", a_rdata, 32'd0);
    a_req = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    check("rstmid_no_ack", a_ack, 1'b0);
    @(negedge Clk);
    check("rstmid_idle_busy", busy, 1'b0);
    check("rstmid_idle_ack", a_ack, 1'b0);
    check("rstmid_mem_unchanged", {mem[16'hff53], mem[16'hff52], mem[16'hff51], mem[16'hff50]},
          32'h01010101);
    do_access(1'b0, 3'd0, 16'hff50, 32'h0, 2'd0, 32'h01010101, "post_rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port arbiter and sequencer in front of the data memory. It shares the single memory port between requester A (CPU load/store unit) and requester B (debug/DMA loader). Each access is latched into registers, driven to the memory for exactly one cycle, and acknowledged with registered read data. Round-robin arbitration prevents either requester from starving the other.

Parameters:
AW, 16, address width (memory Ad)
DW, 32, data width (WrData/DM)

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  asynchronous, active-low reset
a_req  in  1  requester A access request; held with fields stable until a_ack
a_wr  in  3  A write code (0 read, 1 word, 2 byte, 3 word-special, 4 halfword)
a_ad  in  AW  A byte address
a_wdata  in  DW  A write data
a_cut  in  2  A read cut select (0 word, 1 byte, 2 half, 3 word)
a_ack  out  1  one-cycle completion pulse to A
a_rdata  out  DW  A read data, valid while a_ack=1
b_req, b_wr, b_ad, b_wdata, b_cut  in  1/3/AW/DW/2  requester B, same meaning
b_ack  out  1  one-cycle completion pulse to B
b_rdata  out  DW  B read data, valid while b_ack=1
Ad  out  AW  memory address
WrData  out  DW  memory write data
MemWr  out  3  memory write code
DMcut_sel  out  2  memory cut select
DM  in  DW  memory read data (combinational from Ad/DMcut_sel/MemWr)
busy  out  1  high in ACCESS and DONE

Behaviour:
- States: IDLE, ACCESS, DONE. Reset -> IDLE, rr_last=B (A wins the first tie), latched request registers cleared.
- Reset values: a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, Ad=0, WrData=0, MemWr=0, DMcut_sel=0.
- IDLE: if any req, pick the winner, latch its wr/ad/wdata/cut and its id into registers, go to ACCESS. If none, stay.
- Pick rule: one req -> that port. Both -> the port not equal to rr_last. rr_last updates on every grant.
- ACCESS (exactly 1 cycle): Ad, WrData, MemWr, DMcut_sel are driven from the latched registers. The memory commits the write at the edge ending ACCESS. DM is sampled into the winner's rdata register at that same edge for every access, including writes. Go to DONE.
- Outside ACCESS, MemWr=0, Ad=0, WrData=0, DMcut_sel=0. No spurious writes are allowed.
- DONE: the winner's ack=1 for this one cycle, and its rdata holds the sampled value. Arbitration in DONE considers only the other port's req. If it is asserted, latch it and go directly to ACCESS. Otherwise go to IDLE.
- rdata registers hold their value until the next access for that port.
- Latency: an idle-bus request seen at edge N has ACCESS in cycle N+1 and ack in cycle N+2. Contended throughput is one access per 2 cycles, alternating A/B.
- Requester rule: keep req and fields stable until the cycle ack=1. It may drop req or present a new request from the next cycle on. Changing fields while pending is illegal, but the latched copy is unaffected.
- Request fields are latched, so input changes after grant do not affect the ACCESS cycle.
- MemWr=3 reads back 1 from the memory. The arbiter passes this through unmodified.
- Address wrap: Ad is passed through unmodified. Bounds checks and +1..+3 byte wrap belong to the memory.
- Reset asserted mid-ACCESS or mid-DONE: all outputs return to reset values asynchronously and the state goes to IDLE. A write whose commit edge has not occurred is lost, and no ack is issued.
- Simultaneous a_req and b_req rising in IDLE: exactly one ack per access. A and B acks are never high together.

Test Plan:
- Single read: mem[0xff10..13]=0x11223344, A reads ad=0xff10, cut=0 -> a_ack 2 cycles later with a_rdata=0x11223344. MemWr=0 throughout.
- Byte write then read: B writes wr=2, ad=0xff20, wdata=0xAABBCCDD; A then reads cut=1 -> a_rdata=0x000000DD. MemWr=2 for exactly one cycle.
- Contention: A and B request continuously from reset -> ack order A,B,A,B… every 2 cycles, never both high. Each read returns its own address's data.
- Field stability: change a_ad from 0xff10 to 0xff40 during ACCESS -> memory still sees 0xff10. Response is data from 0xff10.
- Reset mid-ACCESS of a word write to 0xff30 -> no ack, outputs zero, state IDLE. A request after release is served normally.
- Special write: A issues wr=3, cut=0 -> a_rdata=0x00000001. The following read of the same address returns the written word.
